mod15_seq_checker: RTL and testbench
====================================

// Module: mod15_seq_checker
// PURPOSE
//  In-system checker on the observing side of the mod-15 up/down load counter.
//  Each clock it samples the counter's control inputs and its output value, and predicts the next output.
//  It compares that prediction with the value the counter actually produces and flags any mismatch.
//  It sits beside the counter in the datapath.
//  It reports error pulses, an error class, a saturating error tally and a lock indication to status/debug logic.
// PARAMETERS
//  WIDTH     4   width of the observed counter value and load data
//  MAX       14  terminal value; the counter wraps to 0 when its value equals MAX
//  ERR_CNT_W 8   width of the saturating error counter
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  rst        in   1          reset, synchronous, active-high
//  en         in   1          checking enable; 0 = idle/unsynced
//  cnt_rst    in   1          observed counter's reset input
//  cnt_load   in   1          observed counter's load input
//  cnt_mode   in   1          observed counter's mode input (1 = up, 0 = down)
//  cnt_data   in   WIDTH      observed counter's load data
//  cnt_value  in   WIDTH      observed counter output
//  exp_value  out  WIDTH      registered prediction of the next cnt_value
//  locked     out  1          1 while in TRACK state
//  err        out  1          one-cycle error pulse
//  err_type   out  2          class of the last error; held until the next error
//  err_count  out  ERR_CNT_W  number of errors, saturating at all-ones
// BEHAVIOUR
//  Reset (rst=1): state=UNSYNC, exp_value=0, locked=0, err=0, err_type=0, err_count=0.
//  rst has priority over en.
//  Prediction f(), evaluated at posedge k on the inputs present just before the edge; priority order:
//   1. cnt_rst=1               -> exp=0,        class=2'b11
//   2. else cnt_load=1         -> exp=cnt_data, class=2'b10
//   3. else cnt_value==MAX     -> exp=0,        class=2'b01 (independent of mode)
//   4. else cnt_mode=1         -> exp=cnt_value+1 mod 2^WIDTH, class=2'b01
//   5. else                    -> exp=cnt_value-1 mod 2^WIDTH, class=2'b01
//  Wrap rules: 0 counting down gives 2^WIDTH-1 (15), which is legal.
//   15 counting up gives 0. Only the value MAX forces the wrap to 0.
//  The class from step 1-5 is registered with exp_value as pend_class.
//  FSM:
//   UNSYNC: when en=1, compute f() and load exp_value/pend_class, then go to TRACK. No compare, err=0.
//   TRACK: at each edge with en=1:
//    - compare cnt_value against exp_value;
//    - on mismatch: err=1, err_type=pend_class, err_count+=1 (saturating);
//    - then reload exp_value/pend_class from f(); stay in TRACK.
//   en=0 in any state: go to UNSYNC next edge, err=0. exp_value, err_type and err_count hold.
//  Latency: a wrong cnt_value present before edge k+1 gives err=1 in the cycle after edge k+1.
//   That value was predicted at edge k.
//  After a mismatch the checker resyncs to the observed value: the next prediction uses cnt_value, not exp_value.
//   A single corrupted count therefore gives exactly one err pulse.
//  err is high for one cycle per mismatching edge. Back-to-back mismatches give consecutive pulses.
//  locked = (state==TRACK). It stays 1 through errors.
//  rst mid-TRACK: every output and state returns to its reset value at that edge.
//  exp_value is internal state exported for debug. It is defined in UNSYNC too (holds its last value).
// STRUCTURE
//  Shared package mod15_pkg:
//   - state enum {UNSYNC, TRACK};
//   - err class constants ERR_NONE=2'b00, ERR_CNT=2'b01, ERR_LOAD=2'b10, ERR_RST=2'b11;
//   - WIDTH/MAX defaults.
//  Sub-module mod15_next_pred: purely combinational f().
//   Inputs: rst, load, mode, data, value. Outputs: exp, class.
//   Reused by the formal checker. The FSM and counters live in the top.
// TESTING
//  1. rst=1 then en=1, cnt_mode=1, correct counting 0..14,0 -> locked=1 from 2nd edge, err never 1, err_count=0.
//  2. Down count from 0 -> cnt_value 15 accepted, next prediction 14, no err.
//  3. cnt_value=14 with cnt_mode=0 -> exp_value=0. Feed 13 instead -> err=1 for one cycle, err_type=01, err_count=1.
//  4. cnt_load=1, cnt_data=9, feed 8 next cycle -> err, err_type=10. Then correct counting from 8 -> no further err.
//  5. Assert cnt_rst, feed 3 next cycle -> err_type=11. Also: force 300 mismatches with ERR_CNT_W=8 -> err_count sticks at 255.
//  6. rst mid-TRACK with err_count=5 -> all outputs 0 next cycle. en=0 -> locked=0 and no err despite bad cnt_value.

Source files
------------

// File: rtl/mod15_pkg.sv
// Shared types and constants for the mod-15 counter checker.
package mod15_pkg;

    // Checker synchronisation state
    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } state_t;

    // Error classes: which rule produced the prediction that was violated
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CNT  = 2'b01;
    localparam logic [1:0] ERR_LOAD = 2'b10;
    localparam logic [1:0] ERR_RST  = 2'b11;

    // Default geometry of the observed counter
    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_MAX   = 14;

endpackage

// File: rtl/mod15_next_pred.sv
// Combinational next-value predictor for the mod-15 up/down load counter.
// Given the counter's control inputs and current value, returns the value the
// counter must show after the next clock edge and the rule class that applied.
// The class output is named pred_class because "class" is a reserved word.
module mod15_next_pred
    import mod15_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned MAX   = DEF_MAX
) (
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] exp,
    output logic [1:0]       pred_class
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    // Priority-ordered prediction: reset, load, terminal wrap, up, down
    always_comb begin
        exp        = '0;
        pred_class = ERR_CNT;
        if (rst) begin
            exp        = '0;
            pred_class = ERR_RST;
        end else if (load) begin
            exp        = data;
            pred_class = ERR_LOAD;
        end else if (value == MAX_V) begin
            exp        = '0;
            pred_class = ERR_CNT;
        end else if (mode) begin
            exp        = value + ONE_V;
            pred_class = ERR_CNT;
        end else begin
            exp        = value - ONE_V;
            pred_class = ERR_CNT;
        end
    end

endmodule

// File: rtl/mod15_seq_checker.sv
// In-system checker for the mod-15 up/down load counter.
// Predicts each next counter value, compares it against the observed value one
// edge later, and reports error pulses, error class, a saturating error tally
// and a lock indication. After a mismatch the next prediction is taken from the
// observed value, so one corrupted count yields exactly one error pulse.
module mod15_seq_checker
    import mod15_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX       = DEF_MAX,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cnt_rst,
    input  logic                 cnt_load,
    input  logic                 cnt_mode,
    input  logic [WIDTH-1:0]     cnt_data,
    input  logic [WIDTH-1:0]     cnt_value,
    output logic [WIDTH-1:0]     exp_value,
    output logic                 locked,
    output logic                 err,
    output logic [1:0]           err_type,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [1:0]           pend_class_q, pend_class_d;
    logic                 err_q, err_d;
    logic [1:0]           err_type_q, err_type_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0]     pred_exp;
    logic [1:0]           pred_class;

    mod15_next_pred #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_pred (
        .rst        (cnt_rst),
        .load       (cnt_load),
        .mode       (cnt_mode),
        .data       (cnt_data),
        .value      (cnt_value),
        .exp        (pred_exp),
        .pred_class (pred_class)
    );

    // Next-state, compare and error bookkeeping
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        pend_class_d = pend_class_q;
        err_d        = 1'b0;
        err_type_d   = err_type_q;
        err_count_d  = err_count_q;

        if (!en) begin
            state_d = UNSYNC;
        end else begin
            if (state_q == TRACK && cnt_value != exp_q) begin
                err_d      = 1'b1;
                err_type_d = pend_class_q;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + CNT_ONE;
                end
            end
            exp_d        = pred_exp;
            pend_class_d = pred_class;
            state_d      = TRACK;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNSYNC;
            exp_q        <= '0;
            pend_class_q <= ERR_NONE;
            err_q        <= 1'b0;
            err_type_q   <= ERR_NONE;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            pend_class_q <= pend_class_d;
            err_q        <= err_d;
            err_type_q   <= err_type_d;
            err_count_q  <= err_count_d;
        end
    end

    assign exp_value = exp_q;
    assign locked    = (state_q == TRACK);
    assign err       = err_q;
    assign err_type  = err_type_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mod15_seq_checker.sv
// Self-checking bench for mod15_seq_checker: a hand-derived vector table,
// directed sequences for full counting and error-count saturation, and random
// stimulus checked against an arithmetic reference model.
module tb_mod15_seq_checker;

    logic       clk;
    logic       rst, en, cnt_rst, cnt_load, cnt_mode;
    logic [3:0] cnt_data, cnt_value;
    logic [3:0] exp_value;
    logic       locked, err;
    logic [1:0] err_type;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_exp, m_class, m_type, m_cnt;
    bit m_locked, m_err;

    mod15_seq_checker #(
        .WIDTH     (4),
        .MAX       (14),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cnt_rst   (cnt_rst),
        .cnt_load  (cnt_load),
        .cnt_mode  (cnt_mode),
        .cnt_data  (cnt_data),
        .cnt_value (cnt_value),
        .exp_value (exp_value),
        .locked    (locked),
        .err       (err),
        .err_type  (err_type),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r, e, cr, ld, md;
        logic [3:0] d, v;
        logic       x_lk, x_err;
        logic [1:0] x_ty;
        logic [7:0] x_cnt;
        logic [3:0] x_exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge(input bit r, e, cr, ld, md, input int d, v);
        if (r) begin
            m_locked = 0; m_exp = 0; m_class = 0; m_err = 0; m_type = 0; m_cnt = 0;
        end else if (!e) begin
            m_locked = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (m_locked && v != m_exp) begin
                m_err  = 1;
                m_type = m_class;
                if (m_cnt < 255) m_cnt++;
            end
            if (cr)            begin m_exp = 0;             m_class = 3; end
            else if (ld)       begin m_exp = d;             m_class = 2; end
            else if (v == 14)  begin m_exp = 0;             m_class = 1; end
            else if (md)       begin m_exp = (v + 1) % 16;  m_class = 1; end
            else               begin m_exp = (v + 15) % 16; m_class = 1; end
            m_locked = 1;
        end
    endtask

    task automatic step(input bit r, e, cr, ld, md, input int d, v);
        @(negedge clk);
        rst = r; en = e; cnt_rst = cr; cnt_load = ld; cnt_mode = md;
        cnt_data = 4'(d); cnt_value = 4'(v);
        @(posedge clk);
        model_edge(r, e, cr, ld, md, d, v);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".locked"},    int'(locked),    int'(m_locked));
        check({tag, ".err"},       int'(err),       int'(m_err));
        check({tag, ".err_type"},  int'(err_type),  m_type);
        check({tag, ".err_count"}, int'(err_count), m_cnt);
        check({tag, ".exp_value"}, int'(exp_value), m_exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnt_rst = 1'b0; cnt_load = 1'b0; cnt_mode = 1'b0;
        cnt_data = '0; cnt_value = '0;
        m_exp = 0; m_class = 0; m_type = 0; m_cnt = 0; m_locked = 0; m_err = 0;

        //            r e cr ld md d  v    lk err ty cnt exp
        vecs.push_back('{1,0,0,0,0, 0, 0,   0, 0, 0, 0,  0});  // reset state
        vecs.push_back('{0,1,0,0,1, 0, 0,   1, 0, 0, 0,  1});  // sync, lock
        vecs.push_back('{0,1,0,0,1, 0, 1,   1, 0, 0, 0,  2});
        vecs.push_back('{0,1,0,0,1, 0, 2,   1, 0, 0, 0,  3});
        vecs.push_back('{0,1,0,0,0, 0, 3,   1, 0, 0, 0,  2});  // switch to down
        vecs.push_back('{0,1,0,0,0, 0, 2,   1, 0, 0, 0,  1});
        vecs.push_back('{0,1,0,0,0, 0, 1,   1, 0, 0, 0,  0});
        vecs.push_back('{0,1,0,0,0, 0, 0,   1, 0, 0, 0, 15});  // 0 down -> 15
        vecs.push_back('{0,1,0,0,0, 0,15,   1, 0, 0, 0, 14});  // 15 accepted
        vecs.push_back('{0,1,0,0,0, 0,14,   1, 0, 0, 0,  0});  // MAX wraps even down
        vecs.push_back('{0,1,0,0,0, 0,13,   1, 1, 1, 1, 12});  // count error, resync
        vecs.push_back('{0,1,0,1,0, 9,12,   1, 0, 1, 1,  9});  // load 9
        vecs.push_back('{0,1,0,0,1, 0, 8,   1, 1, 2, 2,  9});  // load error
        vecs.push_back('{0,1,1,0,1, 0, 9,   1, 0, 2, 2,  0});  // cnt_rst
        vecs.push_back('{0,1,0,0,1, 0, 3,   1, 1, 3, 3,  4});  // reset error
        vecs.push_back('{0,0,0,0,1, 0, 4,   0, 0, 3, 3,  4});  // en=0 unlocks
        vecs.push_back('{0,0,0,0,1, 0, 7,   0, 0, 3, 3,  4});  // bad value ignored
        vecs.push_back('{0,1,0,0,1, 0, 7,   1, 0, 3, 3,  8});  // resync, no compare
        vecs.push_back('{0,1,0,0,1, 0, 9,   1, 1, 1, 4, 10});
        vecs.push_back('{0,1,0,0,1, 0,10,   1, 0, 1, 4, 11});
        vecs.push_back('{0,1,0,0,1, 0, 5,   1, 1, 1, 5,  6});  // err_count=5
        vecs.push_back('{1,1,0,0,1, 0, 5,   0, 0, 0, 0,  0});  // rst mid-TRACK
        vecs.push_back('{1,1,0,0,1, 0, 3,   0, 0, 0, 0,  0});  // rst beats en

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].e, vecs[i].cr, vecs[i].ld, vecs[i].md,
                 int'(vecs[i].d), int'(vecs[i].v));
            check($sformatf("vec%0d.locked", i),    int'(locked),    int'(vecs[i].x_lk));
            check($sformatf("vec%0d.err", i),       int'(err),       int'(vecs[i].x_err));
            check($sformatf("vec%0d.err_type", i),  int'(err_type),  int'(vecs[i].x_ty));
            check($sformatf("vec%0d.err_count", i), int'(err_count), int'(vecs[i].x_cnt));
            check($sformatf("vec%0d.exp_value", i), int'(exp_value), int'(vecs[i].x_exp));
        end

        // Full up count 0..14 then wrap to 0: never an error
        step(1, 0, 0, 0, 1, 0, 0);
        for (int unsigned k = 0; k <= 15; k++) begin
            step(0, 1, 0, 0, 1, 0, int'(k % 15));
            check("upcount.err", int'(err), 0);
            check_model("upcount");
        end
        check("upcount.final_count", int'(err_count), 0);

        // Persistent mismatches: err held high, tally sticks at 255
        step(1, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        for (int unsigned k = 0; k < 300; k++) begin
            step(0, 1, 0, 0, 1, 0, m_exp ^ 1);
            check("sat.err", int'(err), 1);
        end
        check("sat.err_count", int'(err_count), 255);
        check("sat.err_type", int'(err_type), 1);

        // Random stimulus against the reference model
        step(1, 0, 0, 0, 0, 0, 0);
        for (int unsigned k = 0; k < 3000; k++) begin
            bit r, e, cr, ld, md;
            int d, v;
            r  = ($urandom_range(63) == 0);
            e  = ($urandom_range(7) != 0);
            cr = ($urandom_range(15) == 0);
            ld = ($urandom_range(7) == 0);
            md = $urandom_range(1);
            d  = $urandom_range(15);
            v  = ($urandom_range(3) != 0) ? m_exp : $urandom_range(15);
            step(r, e, cr, ld, md, d, v);
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
